// File: rtl/matrix_pkg.sv
// Shared definitions for the dot-matrix column driver and its loader.
// Exports: column geometry, write-interface field widths, loader FSM states.
package matrix_pkg;

    localparam int COLS     = 32;
    localparam int COL_ID_W = 5;
    localparam int ROW_W    = 16;

    typedef logic [COL_ID_W-1:0] col_id_t;
    typedef logic [ROW_W-1:0]    row_t;

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        STROBE,
        HOLD
    } ld_state_e;

endpackage

// File: rtl/scroll_tick_gen.sv
// Scroll prescaler: emits a one-cycle tick every SCROLL_DIV enabled cycles.
// Ports: CLK, RESET (async, active high), scroll_en (clears count when low), tick.
module scroll_tick_gen #(
    parameter int SCROLL_DIV = 2500000
) (
    input  logic CLK,
    input  logic RESET,
    input  logic scroll_en,
    output logic tick
);

    localparam int CW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(SCROLL_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (!scroll_en) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            cnt_d = '0;
            tick  = 1'b1;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/column_stream_loader.sv
// Streams a 32-column window of a scrolling message buffer into the column driver.
// Ports: CLK/RESET, buffer write port (wr_*), start, scroll_en,
//        driver interface (column_id, in_column, LOAD), busy, offset.
module column_stream_loader
    import matrix_pkg::*;
#(
    parameter int MSG_LEN    = 64,
    parameter int SCROLL_DIV = 2500000,
    parameter int SETUP_CYC  = 2,
    parameter int STROBE_CYC = 2,
    localparam int AW        = $clog2(MSG_LEN)
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [ROW_W-1:0]    wr_data,
    input  logic                start,
    input  logic                scroll_en,
    output logic [COL_ID_W-1:0] column_id,
    output logic [ROW_W-1:0]    in_column,
    output logic                LOAD,
    output logic                busy,
    output logic [AW-1:0]       offset
);

    localparam int CMAX  = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
    localparam int CNT_W = $clog2(CMAX + 1);
    localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_CYC - 1);
    localparam col_id_t          K_LAST      = COL_ID_W'(COLS - 1);

    ld_state_e  state_q, state_d;
    col_id_t    k_q, k_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [AW-1:0] offset_q, offset_d;
    logic       busy_q, busy_d;
    logic       load_q, load_d;
    col_id_t    col_id_q, col_id_d;
    row_t       col_q, col_d;
    logic       pend_scroll_q, pend_scroll_d;
    logic       pend_refresh_q, pend_refresh_d;
    row_t       msg_q [MSG_LEN];
    row_t       msg_d [MSG_LEN];
    logic       consume;
    logic       fetch;
    logic       tick;

    scroll_tick_gen #(
        .SCROLL_DIV(SCROLL_DIV)
    ) u_tick (
        .CLK      (CLK),
        .RESET    (RESET),
        .scroll_en(scroll_en),
        .tick     (tick)
    );

    // Fetch reads the pre-write buffer, so a same-cycle write is not seen.
    always_comb begin
        msg_d = msg_q;
        if (wr_en) begin
            msg_d[wr_addr] = wr_data;
        end
    end

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        cnt_d    = cnt_q;
        offset_d = offset_q;
        busy_d   = busy_q;
        load_d   = 1'b0;
        col_id_d = col_id_q;
        col_d    = col_q;
        consume  = 1'b0;
        fetch    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (pend_scroll_q || pend_refresh_q) begin
                    consume = 1'b1;
                    if (pend_scroll_q) begin
                        offset_d = offset_q + AW'(1);
                    end
                    k_d     = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    fetch   = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    cnt_d   = '0;
                    load_d  = 1'b1;
                    state_d = STROBE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STROBE: begin
                if (cnt_q == STROBE_LAST) begin
                    cnt_d   = '0;
                    state_d = HOLD;
                end else begin
                    cnt_d  = cnt_q + CNT_W'(1);
                    load_d = 1'b1;
                end
            end
            HOLD: begin
                if (k_q == K_LAST) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    k_d     = k_q + COL_ID_W'(1);
                    fetch   = 1'b1;
                    state_d = SETUP;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // Data is registered on SETUP entry so it is stable for all of SETUP.
        if (fetch) begin
            col_id_d = k_d;
            col_d    = msg_q[offset_d + AW'(k_d)];
        end
    end

    // Flags are sticky; repeated requests before consumption collapse.
    always_comb begin
        pend_scroll_d  = (consume ? 1'b0 : pend_scroll_q) | tick;
        pend_refresh_d = (consume ? 1'b0 : pend_refresh_q) | start;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q        <= IDLE;
            k_q            <= '0;
            cnt_q          <= '0;
            offset_q       <= '0;
            busy_q         <= 1'b0;
            load_q         <= 1'b0;
            col_id_q       <= '0;
            col_q          <= '0;
            pend_scroll_q  <= 1'b0;
            pend_refresh_q <= 1'b0;
            msg_q          <= '{default: '0};
        end else begin
            state_q        <= state_d;
            k_q            <= k_d;
            cnt_q          <= cnt_d;
            offset_q       <= offset_d;
            busy_q         <= busy_d;
            load_q         <= load_d;
            col_id_q       <= col_id_d;
            col_q          <= col_d;
            pend_scroll_q  <= pend_scroll_d;
            pend_refresh_q <= pend_refresh_d;
            msg_q          <= msg_d;
        end
    end

    assign column_id = col_id_q;
    assign in_column = col_q;
    assign LOAD      = load_q;
    assign busy      = busy_q;
    assign offset    = offset_q;

endmodule

// File: tb/tb_column_stream_loader.sv
// Self-checking bench for column_stream_loader.
// Reference: message array plus window offset; frames are compared column by column.
module tb_column_stream_loader;

    localparam int ML  = 64;
    localparam int DIV = 4;
    localparam int SU  = 2;
    localparam int ST  = 2;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [15:0] wr_data;
    logic        start;
    logic        scroll_en;
    logic [4:0]  column_id;
    logic [15:0] in_column;
    logic        LOAD;
    logic        busy;
    logic [5:0]  offset;

    always #5 CLK = ~CLK;

    column_stream_loader #(
        .MSG_LEN   (ML),
        .SCROLL_DIV(DIV),
        .SETUP_CYC (SU),
        .STROBE_CYC(ST)
    ) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .start    (start),
        .scroll_en(scroll_en),
        .column_id(column_id),
        .in_column(in_column),
        .LOAD     (LOAD),
        .busy     (busy),
        .offset   (offset)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference state
    logic [15:0] mbuf [ML];
    int          moff;
    logic [15:0] exp_col [32];

    // Protocol monitor
    bit          mon_en = 1'b0;
    int          frames = 0;
    int          rises  = 0;
    int          busy_run, idle_run, gap_last, hi_run, stab, ncap;
    logic [4:0]  p_id;
    logic [15:0] p_col;
    logic        p_load, p_busy;
    logic [5:0]  p_off;
    logic [4:0]  cap_id [32];
    logic [15:0] cap_col [32];

    always @(negedge CLK) begin
        if (!mon_en) begin
            p_id = '0; p_col = '0; p_load = 1'b0; p_busy = 1'b0;
            p_off = offset; stab = 0; busy_run = 0; idle_run = 0; hi_run = 0;
        end else begin
            if (column_id == p_id && in_column == p_col) stab++;
            else stab = 1;
            if (busy && !p_busy) begin
                frames++;
                gap_last = idle_run;
                idle_run = 0;
                busy_run = 0;
                ncap = 0;
            end
            if (!busy && p_busy) chk("busy_len", busy_run, 160);
            if (busy && p_busy) chk("offset_stable", offset, p_off);
            if (busy) busy_run++;
            else idle_run++;
            if (LOAD && !p_load) begin
                rises++;
                chk("setup_time", longint'(stab - 1 >= SU), 1);
                if (ncap < 32) begin
                    cap_id[ncap]  = column_id;
                    cap_col[ncap] = in_column;
                end
                ncap++;
                hi_run = 1;
            end else if (LOAD) begin
                hi_run++;
            end
            if (!LOAD && p_load) begin
                chk("strobe_len", hi_run, ST);
                chk("hold_data", {column_id, in_column}, {p_id, p_col});
            end
            p_id = column_id; p_col = in_column; p_load = LOAD;
            p_busy = busy; p_off = offset;
        end
    end

    task automatic wr(input logic [5:0] a, input logic [15:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        @(negedge CLK);
        wr_en = 1'b0;
        mbuf[a] = d;
    endtask

    // Issue start and/or one prescaler tick in the same cycle.
    task automatic req(input bit s, input bit t);
        if (t) begin
            scroll_en = 1'b1;
            repeat (3) @(negedge CLK);
        end
        start = s;
        @(negedge CLK);
        start = 1'b0;
        scroll_en = 1'b0;
    endtask

    task automatic wait_idle();
        int z = 0;
        for (int i = 0; i < 2000 && z < 3; i++) begin
            @(negedge CLK);
            z = busy ? 0 : z + 1;
        end
        if (z < 3) chk("idle_timeout", 0, 1);
    endtask

    task automatic wait_col(input logic [4:0] c);
        bit seen = 1'b0;
        for (int i = 0; i < 500 && !seen; i++) begin
            @(negedge CLK);
            seen = LOAD && column_id == c;
        end
        if (!seen) chk("col_timeout", c, 0);
    endtask

    task automatic snap(input int off);
        for (int k = 0; k < 32; k++) exp_col[k] = mbuf[(off + k) % ML];
    endtask

    task automatic check_frame(input string name);
        chk({name, "_ncols"}, ncap, 32);
        for (int k = 0; k < 32; k++) begin
            chk({name, "_col_id"}, cap_id[k], k);
            chk({name, "_col_data"}, cap_col[k], exp_col[k]);
        end
    endtask

    typedef struct {
        bit s;
        bit t;
        int frames;
        int delta;
    } vec_t;

    vec_t tbl [4];

    initial begin
        int f0;
        int r0;
        bit s;
        bit t;

        tbl[0] = '{1'b1, 1'b0, 1, 0};
        tbl[1] = '{1'b0, 1'b1, 1, 1};
        tbl[2] = '{1'b1, 1'b1, 1, 1};
        tbl[3] = '{1'b0, 1'b1, 1, 1};

        RESET = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        start = 1'b0; scroll_en = 1'b0;
        for (int i = 0; i < ML; i++) mbuf[i] = '0;
        moff = 0;
        repeat (3) @(negedge CLK);
        chk("reset_outs", {column_id, in_column, LOAD, busy, offset}, 0);
        RESET = 1'b0;
        mon_en = 1'b1;
        @(negedge CLK);

        // Basic frame
        for (int i = 0; i < ML; i++) wr(6'(i), 16'h1000 + 16'(i));
        snap(0);
        req(1'b1, 1'b0);
        wait_idle();
        chk("basic_frames", frames, 1);
        chk("basic_offset", offset, 0);
        check_frame("basic");

        // Table: request kinds from idle
        for (int v = 0; v < 4; v++) begin
            f0 = frames;
            moff = (moff + tbl[v].delta) % ML;
            snap(moff);
            req(tbl[v].s, tbl[v].t);
            wait_idle();
            chk("tbl_frames", frames - f0, tbl[v].frames);
            chk("tbl_offset", offset, moff);
            check_frame("tbl");
        end

        // Random contents and requests
        for (int it = 0; it < 8; it++) begin
            for (int j = 0; j < 6; j++) wr(6'($urandom), 16'($urandom));
            t = 1'($urandom);
            s = t ? 1'($urandom) : 1'b1;
            moff = (moff + int'(t)) % ML;
            f0 = frames;
            snap(moff);
            req(s, t);
            wait_idle();
            chk("rnd_frames", frames - f0, 1);
            chk("rnd_offset", offset, moff);
            check_frame("rnd");
        end

        // Write hazards inside a frame
        snap(moff);
        req(1'b1, 1'b0);
        wait_col(5'd3);
        wr(6'((moff + 10) % ML), 16'hFFFF);
        exp_col[10] = 16'hFFFF;
        wait_col(5'd4);
        repeat (ST) @(negedge CLK);
        wr(6'((moff + 5) % ML), 16'hBEEF);
        wait_idle();
        check_frame("hazard");
        snap(moff);
        req(1'b1, 1'b0);
        wait_idle();
        check_frame("hazard_after");
        chk("hazard_col5", cap_col[5], 16'hBEEF);

        // Tick collapse during a busy frame
        f0 = frames;
        req(1'b1, 1'b0);
        repeat (10) @(negedge CLK);
        scroll_en = 1'b1;
        repeat (12) @(negedge CLK);
        scroll_en = 1'b0;
        for (int i = 0; i < 400 && frames < f0 + 2; i++) @(negedge CLK);
        chk("collapse_gap", gap_last, 1);
        wait_idle();
        repeat (200) @(negedge CLK);
        chk("collapse_frames", frames - f0, 2);
        moff = (moff + 1) % ML;
        chk("collapse_offset", offset, moff);
        snap(moff);
        check_frame("collapse");

        // Scroll wrap
        for (int i = 0; i < ML && moff != ML - 1; i++) begin
            moff++;
            req(1'b0, 1'b1);
            wait_idle();
        end
        chk("pre_wrap_offset", offset, 63);
        moff = 0;
        snap(0);
        req(1'b0, 1'b1);
        wait_idle();
        chk("wrap_offset", offset, 0);
        check_frame("wrap");
        for (int i = 0; i < 40; i++) begin
            moff++;
            snap(moff);
            req(1'b0, 1'b1);
            wait_idle();
        end
        chk("off40_offset", offset, 40);
        check_frame("off40");
        chk("off40_col31", cap_col[31], mbuf[7]);

        // Reset in the middle of a strobe
        req(1'b1, 1'b0);
        wait_col(5'd5);
        mon_en = 1'b0;
        RESET = 1'b1;
        #1;
        chk("rst_load", LOAD, 0);
        chk("rst_outs", {column_id, in_column, LOAD, busy, offset}, 0);
        @(negedge CLK);
        RESET = 1'b0;
        for (int i = 0; i < ML; i++) mbuf[i] = '0;
        moff = 0;
        r0 = rises;
        mon_en = 1'b1;
        repeat (200) @(negedge CLK);
        chk("rst_no_load", rises, r0);
        chk("rst_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/column_stream_loader.md
Name: column_stream_loader

Overview:
- Upstream feeder for the 32x16 dot-matrix column driver.
- Holds a message buffer of MSG_LEN 16-bit columns.
- Streams a 32-column window of that buffer into the driver's column store over its column_id / in_column / LOAD write interface, one column at a time, with guaranteed data setup/hold around each LOAD rising edge.
- Advances the window by one column per scroll tick, giving horizontal scrolling text.

Parameters:
- MSG_LEN, 64, message buffer depth in columns; power of two, >= 32.
- SCROLL_DIV, 2500000, CLK cycles per scroll tick; >= 1.
- SETUP_CYC, 2, cycles column_id/in_column are stable before LOAD rises; >= 1.
- STROBE_CYC, 2, cycles LOAD stays high; >= 1.

Ports:
- CLK  in  1  system clock.
- RESET  in  1  asynchronous, active-high reset.
- wr_en  in  1  message buffer write strobe.
- wr_addr  in  log2(MSG_LEN)  message buffer write address.
- wr_data  in  16  message buffer write data (bit = dot lit).
- start  in  1  one-cycle request: refresh the driver at the current offset.
- scroll_en  in  1  enables the scroll prescaler.
- column_id  out  5  driver column address.
- in_column  out  16  driver column data.
- LOAD  out  1  driver write strobe; the driver captures on the rising edge.
- busy  out  1  high while a frame is being streamed.
- offset  out  log2(MSG_LEN)  current window start index.

Behaviour:
- Reset: asynchronous, active-high. One clock (CLK). While RESET is high, all of the following are 0 and state is IDLE: column_id, in_column, LOAD, busy, offset, pending flags, prescaler count, message buffer. LOAD drops to 0 immediately on RESET assertion, including mid-strobe.
- Buffer writes:
  - Synchronous; allowed in every state.
  - A write landing in the same cycle as a column fetch of that address returns the old data to the fetch.
- Prescaler:
  - The counter increments while scroll_en = 1 and wraps at SCROLL_DIV-1.
  - The wrap cycle produces a one-cycle tick.
  - scroll_en = 0 clears the counter to 0 and suppresses ticks.
- Requests:
  - A tick sets pend_scroll; start sets pend_refresh. Both are sticky until consumed.
  - Multiple ticks before consumption collapse into one (offset advances by 1, not N).
- FSM states: IDLE, SETUP, STROBE, HOLD.
- IDLE:
  - If pend_scroll or pend_refresh: if pend_scroll, offset <= (offset+1) mod MSG_LEN. Clear both flags, k <= 0, busy <= 1, go to SETUP.
  - The offset changes only here, so a frame never tears.
- SETUP entry:
  - column_id <= k; in_column <= buf[(offset+k) mod MSG_LEN], registered.
  - LOAD = 0; hold for SETUP_CYC cycles, then go to STROBE.
- STROBE: LOAD = 1 for STROBE_CYC cycles; column_id and in_column unchanged. Then go to HOLD.
- HOLD:
  - One cycle with LOAD = 0 and data still unchanged.
  - If k = 31: busy <= 0, go to IDLE. Else k <= k+1, go to SETUP.
- Timing:
  - One column takes SETUP_CYC+STROBE_CYC+1 cycles; a frame takes 32x that (160 cycles at defaults).
  - First LOAD rise is SETUP_CYC+1 cycles after the request is consumed in IDLE.
- Requests during busy: latched into the pending flags and serviced immediately after the frame ends. IDLE is held for exactly one cycle between back-to-back frames.
- Simultaneous tick and start: offset advances once; one frame is streamed.
- Window wrap: offset + k is taken modulo MSG_LEN (natural truncation of the log2(MSG_LEN)-bit sum).
- column_id ordering: 0..31 ascending. Column-order remapping is owned by the driver, not this block.

Decomposition:
- Shared package matrix_pkg:
  - COLS = 32, COL_ID_W = 5, ROW_W = 16.
  - FSM state enum {IDLE, SETUP, STROBE, HOLD}.
  - Driver write-interface field widths, so the driver and loader agree on them.
- One natural sub-module: scroll_tick_gen, the SCROLL_DIV prescaler. Inputs CLK, RESET, scroll_en; output tick.

Test Plan:
- Reset mid-strobe: assert RESET while LOAD = 1 in column 5 -> LOAD = 0 in the same cycle; all outputs 0; busy = 0; after release no LOAD until start.
- Basic frame: write buf[i] = 16'h1000 + i for i = 0..63, pulse start -> exactly 32 LOAD rising edges, column_id 0..31, in_column 16'h1000..16'h101F. Each edge is preceded by >= 2 stable cycles and followed by >= 1 stable cycle. busy is high 160 cycles; offset stays 0.
- Scroll wrap: SCROLL_DIV = 4, offset preset to 63 via 63 ticks -> next tick frame gives offset = 0. At offset 40, column 31 carries buf[7].
- Tick collapse: 3 ticks during one busy frame -> the next frame starts one idle cycle later with offset +1 only; no third frame.
- Simultaneous start and tick in IDLE -> one frame, offset +1.
- Write hazard: rewrite buf[offset+10] to 16'hFFFF while column 3 is strobing -> column 10 carries 16'hFFFF; column 3 is unaffected.
